cdb_rr_scheduler: RTL and testbench

Round-robin scheduler for the Common Data Bus. It shares the single CDB between N_SRC functional-unit result ports (ADD1, ADD2, further units later) using a Done/Ack handshake. Each cycle it grants one pending source and broadcasts that source's tag and result for exactly one cycle to register_status and the reservation stations. It replaces the fixed-priority CDB arbitration path, so a unit that completes back-to-back cannot starve the others.

---
 rtl/tomasulo_pkg.sv | 24 ++
 rtl/cdb_rr_scheduler_if.sv | 29 ++
 rtl/rr_priority_pick.sv | 29 ++
 rtl/cdb_rr_scheduler.sv | 74 +++++++
 tb/tb_cdb_rr_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: bus widths, reservation-station tags, idle bus value
// and the CDB scheduler state type.
package tomasulo_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;

  localparam logic [TAG_W-1:0] FREE_REGISTER    = 3'd0;
  localparam logic [TAG_W-1:0] RES_STATION_ADD1 = 3'd1;
  localparam logic [TAG_W-1:0] RES_STATION_ADD2 = 3'd2;

  localparam logic [DATA_W-1:0] SEM_VALOR = 16'hFFF0;

  typedef enum logic {
    CDB_IDLE  = 1'b0,
    CDB_BCAST = 1'b1
  } cdb_state_e;

  // Pointer width that stays legal for a single-source configuration.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_scheduler_if.sv
// Done/Ack handshake between functional-unit result ports and the CDB scheduler,
// plus the broadcast bus seen by register_status and the reservation stations.
interface cdb_rr_scheduler_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int PTR_W  = tomasulo_pkg::ptr_width(N_SRC)
);

  logic [N_SRC-1:0]        Done;
  logic [N_SRC*DATA_W-1:0] Q;
  logic                    Hold_CDB;
  logic [N_SRC-1:0]        Ack;
  logic                    CDB_Valid;
  logic [TAG_W-1:0]        Qi_CDB;
  logic [DATA_W-1:0]       Qi_CDB_data;
  logic [PTR_W-1:0]        Rr_ptr;

  modport master (
    input  Done, Q, Hold_CDB,
    output Ack, CDB_Valid, Qi_CDB, Qi_CDB_data, Rr_ptr
  );

  modport slave (
    output Done, Q, Hold_CDB,
    input  Ack, CDB_Valid, Qi_CDB, Qi_CDB_data, Rr_ptr
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
// Shared with the dispatch-side station selector.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    any_grant = 1'b0;
    // Scan from the farthest offset down so the closest request to ptr wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant_idx = PTR_W'(idx);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_rr_scheduler.sv
// Round-robin Common Data Bus scheduler: grants one pending functional unit per cycle
// and broadcasts its tag and result for exactly one cycle.
module cdb_rr_scheduler #(
  parameter int                 N_SRC     = 4,
  parameter int                 DATA_W    = 16,
  parameter int                 TAG_W     = 3,
  parameter logic [DATA_W-1:0]  IDLE_DATA = tomasulo_pkg::SEM_VALOR
) (
  input  logic                Clock,
  input  logic                Reset,
  cdb_rr_scheduler_if.master  bus
);

  localparam int PTR_W = tomasulo_pkg::ptr_width(N_SRC);

  tomasulo_pkg::cdb_state_e state_reg;
  logic [N_SRC-1:0]  ack_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [DATA_W-1:0] data_reg;
  logic [PTR_W-1:0]  ptr_reg;

  logic [N_SRC-1:0]  eligible;
  logic [PTR_W-1:0]  grant_idx;
  logic              any_grant;
  logic              grant_fire;
  logic [DATA_W-1:0] q_src [N_SRC];

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_q_unpack
    assign q_src[gi] = bus.Q[gi*DATA_W +: DATA_W];
  end

  // Masking with the live Ack keeps a source from being regranted before it has
  // seen its Ack and had a chance to lower Done.
  assign eligible   = bus.Done & ~ack_reg;
  assign grant_fire = any_grant & ~bus.Hold_CDB;

  rr_priority_pick #(
    .N     (N_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .req       (eligible),
    .ptr       (ptr_reg),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= tomasulo_pkg::CDB_IDLE;
      ack_reg   <= '0;
      tag_reg   <= TAG_W'(tomasulo_pkg::FREE_REGISTER);
      data_reg  <= IDLE_DATA;
      ptr_reg   <= '0;
    end else if (grant_fire) begin
      state_reg <= tomasulo_pkg::CDB_BCAST;
      ack_reg   <= N_SRC'(1) << grant_idx;
      tag_reg   <= TAG_W'(grant_idx) + TAG_W'(tomasulo_pkg::RES_STATION_ADD1);
      data_reg  <= q_src[grant_idx];
      ptr_reg   <= (grant_idx == PTR_W'(N_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
    end else begin
      state_reg <= tomasulo_pkg::CDB_IDLE;
      ack_reg   <= '0;
      tag_reg   <= TAG_W'(tomasulo_pkg::FREE_REGISTER);
      data_reg  <= IDLE_DATA;
    end
  end

  assign bus.Ack         = ack_reg;
  assign bus.CDB_Valid   = (state_reg == tomasulo_pkg::CDB_BCAST);
  assign bus.Qi_CDB      = tag_reg;
  assign bus.Qi_CDB_data = data_reg;
  assign bus.Rr_ptr      = ptr_reg;

endmodule

// File: tb/tb_cdb_rr_scheduler.sv
// Self-checking bench for cdb_rr_scheduler: directed scenarios plus randomized
// Done/Ack traffic, all checked against a queue-free round-robin reference model.
module tb_cdb_rr_scheduler;
  import tomasulo_pkg::*;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int VW = N + 1 + TAG_W + DATA_W + PW;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic [N-1:0]      done_drv;
  logic              hold_drv;
  logic [DATA_W-1:0] q_val [N];

  cdb_rr_scheduler_if #(.N_SRC(N), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  cdb_rr_scheduler #(
    .N_SRC(N), .DATA_W(DATA_W), .TAG_W(TAG_W), .IDLE_DATA(SEM_VALOR)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always_comb begin
    bus.Q = '0;
    for (int i = 0; i < N; i++) bus.Q[i*DATA_W +: DATA_W] = q_val[i];
  end
  assign bus.Done     = done_drv;
  assign bus.Hold_CDB = hold_drv;

  logic [VW-1:0] act_vec;
  logic [VW-1:0] exp_vec;
  assign act_vec = {bus.Ack, bus.CDB_Valid, bus.Qi_CDB, bus.Qi_CDB_data, bus.Rr_ptr};

  int total = 0;
  int bad   = 0;

  // Reference state: next priority index and the source acknowledged last cycle.
  int m_ptr  = 0;
  int m_last = -1;
  int exp_g  = -1;

  function automatic logic [VW-1:0] idle_vec(input int ptr);
    return {{N{1'b0}}, 1'b0, {TAG_W{1'b0}}, SEM_VALOR, PW'(ptr)};
  endfunction

  // Predict the broadcast from the inputs present now, then cross the rising edge.
  task automatic tick();
    int g;
    g = -1;
    if (!hold_drv) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && done_drv[i] && i != m_last) g = i;
      end
    end
    if (g >= 0) begin
      exp_vec = {N'(1 << g), 1'b1, TAG_W'(g + 1), q_val[g], PW'((g + 1) % N)};
      m_ptr   = (g + 1) % N;
    end else begin
      exp_vec = idle_vec(m_ptr);
    end
    m_last = g;
    exp_g  = g;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset    = 1'b1;
    done_drv = '0;
    hold_drv = 1'b0;
    m_ptr    = 0;
    m_last   = -1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    done_drv = '0;
    hold_drv = 1'b0;
    for (int i = 0; i < N; i++) q_val[i] = '0;
    repeat (2) @(posedge Clock);
    #1;
    total++;
    if (act_vec !== idle_vec(0)) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", act_vec, idle_vec(0));
    end
    @(negedge Clock);
    Reset  = 1'b0;
    m_ptr  = 0;
    m_last = -1;
    @(negedge Clock);
    done_drv = 4'b0001;
    q_val[0] = 16'h0005;
    tick();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL reset_pre_bcast: got %h want %h", act_vec, exp_vec);
    end
    #2;
    Reset    = 1'b1;
    done_drv = '0;
    m_ptr    = 0;
    m_last   = -1;
    #1;
    total++;
    if (act_vec !== idle_vec(0)) begin
      bad++;
      $display("FAIL reset_mid_bcast: got %h want %h", act_vec, idle_vec(0));
    end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge Clock);
    done_drv = 4'b0010;
    q_val[1] = 16'h0034;
    tick();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL single_model: got %h want %h", act_vec, exp_vec);
    end
    total++;
    if (bus.Qi_CDB !== RES_STATION_ADD2 || bus.Qi_CDB_data !== 16'h0034 ||
        bus.Ack !== 4'b0010 || bus.Rr_ptr !== 2'd2) begin
      bad++;
      $display("FAIL single_fields: got tag=%0d data=%h ack=%b ptr=%0d want tag=2 data=0034 ack=0010 ptr=2",
               bus.Qi_CDB, bus.Qi_CDB_data, bus.Ack, bus.Rr_ptr);
    end
    @(negedge Clock);
    done_drv = '0;
    tick();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL single_after_idle: got %h want %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_all_pending();
    do_reset();
    done_drv = 4'b1111;
    q_val[0] = 16'h0011;
    q_val[1] = 16'h0022;
    q_val[2] = 16'h0033;
    q_val[3] = 16'h0044;
    for (int c = 0; c < N; c++) begin
      tick();
      total++;
      if (act_vec !== exp_vec || bus.Qi_CDB !== TAG_W'(c + 1) || bus.Rr_ptr !== PW'((c + 1) % N)) begin
        bad++;
        $display("FAIL all_pending_%0d: got %h want %h (tag %0d)", c, act_vec, exp_vec, c + 1);
      end
      @(negedge Clock);
      done_drv = done_drv & ~bus.Ack;
    end
    tick();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL all_pending_idle: got %h want %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_back_to_back();
    logic prev_ack0;
    prev_ack0 = 1'b0;
    @(negedge Clock);
    done_drv = 4'b0011;
    q_val[0] = DATA_W'($urandom);
    q_val[1] = DATA_W'($urandom);
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (act_vec !== exp_vec || bus.Qi_CDB !== TAG_W'((c % 2) + 1) || (prev_ack0 && bus.Ack[0])) begin
        bad++;
        $display("FAIL back_to_back_%0d: got %h want %h (tag %0d)", c, act_vec, exp_vec, (c % 2) + 1);
      end
      prev_ack0 = bus.Ack[0];
      @(negedge Clock);
      for (int i = 0; i < 2; i++) if (bus.Ack[i]) q_val[i] = DATA_W'($urandom);
    end
    done_drv = '0;
    tick();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL back_to_back_idle: got %h want %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_hold();
    do_reset();
    done_drv = 4'b0001;
    q_val[0] = 16'h0abc;
    tick();
    @(negedge Clock);
    done_drv = '0;
    tick();
    @(negedge Clock);
    hold_drv = 1'b1;
    done_drv = 4'b1001;
    q_val[0] = DATA_W'($urandom);
    q_val[3] = DATA_W'($urandom);
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (act_vec !== exp_vec || bus.Ack !== 4'b0000 || bus.Rr_ptr !== 2'd1) begin
        bad++;
        $display("FAIL hold_%0d: got %h want %h", c, act_vec, exp_vec);
      end
      @(negedge Clock);
    end
    hold_drv = 1'b0;
    tick();
    total++;
    if (act_vec !== exp_vec || bus.Qi_CDB !== 3'd4) begin
      bad++;
      $display("FAIL hold_release_first: got %h want %h (tag 4)", act_vec, exp_vec);
    end
    @(negedge Clock);
    done_drv[3] = 1'b0;
    tick();
    total++;
    if (act_vec !== exp_vec || bus.Qi_CDB !== 3'd1) begin
      bad++;
      $display("FAIL hold_release_second: got %h want %h (tag 1)", act_vec, exp_vec);
    end
    @(negedge Clock);
    done_drv = '0;
    tick();
  endtask

  task automatic test_wrap();
    @(negedge Clock);
    done_drv = 4'b0100;
    q_val[2] = 16'h0777;
    tick();
    @(negedge Clock);
    done_drv = '0;
    tick();
    total++;
    if (act_vec !== exp_vec || bus.Rr_ptr !== 2'd3) begin
      bad++;
      $display("FAIL wrap_setup: got %h want %h (ptr 3)", act_vec, exp_vec);
    end
    @(negedge Clock);
    done_drv = 4'b0011;
    q_val[0] = 16'h1010;
    q_val[1] = 16'h2020;
    tick();
    total++;
    if (act_vec !== exp_vec || bus.Qi_CDB !== 3'd1 || bus.Rr_ptr !== 2'd1) begin
      bad++;
      $display("FAIL wrap_first: got %h want %h (tag 1 ptr 1)", act_vec, exp_vec);
    end
    @(negedge Clock);
    done_drv[0] = 1'b0;
    tick();
    total++;
    if (act_vec !== exp_vec || bus.Qi_CDB !== 3'd2 || bus.Rr_ptr !== 2'd2) begin
      bad++;
      $display("FAIL wrap_second: got %h want %h (tag 2 ptr 2)", act_vec, exp_vec);
    end
    @(negedge Clock);
    done_drv = '0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge Clock);
      for (int i = 0; i < N; i++) begin
        if (bus.Ack[i]) begin
          if ($urandom_range(1, 0) == 0) done_drv[i] = 1'b0;
          else q_val[i] = DATA_W'($urandom);
        end else if (!done_drv[i] && $urandom_range(9, 0) < 4) begin
          done_drv[i] = 1'b1;
          q_val[i]    = DATA_W'($urandom);
        end
      end
      hold_drv = ($urandom_range(9, 0) == 0);
      tick();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL random_%0d: got %h want %h (grant %0d)", c, act_vec, exp_vec, exp_g);
      end
    end
    @(negedge Clock);
    hold_drv = 1'b0;
    done_drv = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_pending();
    test_back_to_back();
    test_hold();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
